mig_port_bram: RTL and testbench

- BRAM-backed responder for one Spartan-6 MIG user port (cmd / wr-data / rd-data FIFO interface).
- Lets the VRAM client FSMs (framebuffer read/write engine) run in simulation, and on boards, without DDR.
- Accepts commands, buffers write data, executes bursts against an on-chip word memory, and returns read data through a first-word-fall-through (FWFT) FIFO with MIG-equivalent flags.

---
 rtl/mig_port_bram_pkg.sv | 21 ++
 rtl/mig_port_bram_fifo.sv | 64 ++++++
 rtl/mig_port_bram.sv | 200 ++++++++++++++++++++
 tb/tb_mig_port_bram.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_port_bram_pkg.sv
// Shared constants and types for the BRAM-backed MIG user-port responder.
// MIG command encodings, data-path geometry and the executor state type.
package mig_port_bram_pkg;

  localparam logic [2:0] MIG_INSTR_WR    = 3'b000;
  localparam logic [2:0] MIG_INSTR_RD    = 3'b001;
  localparam logic [2:0] MIG_INSTR_WR_AP = 3'b010;
  localparam logic [2:0] MIG_INSTR_RD_AP = 3'b011;
  localparam logic [2:0] MIG_INSTR_REF   = 3'b100;

  localparam int unsigned MIG_BYTE_PER_WORD = 16;
  localparam int unsigned MIG_DATA_WIDTH    = 128;
  localparam int unsigned MIG_BL_WIDTH      = 6;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_WRITE,
    EX_READ
  } exec_state_t;

endpackage

// File: rtl/mig_port_bram_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
// Ports: clk/rst (sync, active high), push/din, pop/dout (dout is the head
// word whenever empty = 0), count/full/empty from the registered occupancy,
// push_drop (push refused: full with no pop), pop_empty (pop while empty).
module sync_fifo_fwft #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             push_drop,
  output logic             pop_empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (cnt != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push && ((cnt != CNT_W'(DEPTH)) || do_pop);
  assign push_drop = push && !do_push;
  assign pop_empty = pop && (cnt == '0);

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mig_port_bram.sv
// mig_port_bram: BRAM-backed responder for one Spartan-6 MIG user port.
// Ports: cmd_* command FIFO push side and flags; wr_* write-data FIFO push
// side, flags, count and underrun; rd_* FWFT read-data FIFO pop side, flags,
// count and sticky overflow; error is the sticky OR of all protocol errors.
// Commands are executed in order against a 2^ADDR_BITS x 128-bit memory.
module mig_port_bram
  import mig_port_bram_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned DATA_DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_en,
  input  logic [2:0]   cmd_instr,
  input  logic [5:0]   cmd_bl,
  input  logic [29:0]  cmd_byte_addr,
  output logic         cmd_empty,
  output logic         cmd_full,
  input  logic         wr_en,
  input  logic [15:0]  wr_mask,
  input  logic [127:0] wr_data,
  output logic         wr_empty,
  output logic         wr_full,
  output logic [6:0]   wr_count,
  output logic         wr_underrun,
  input  logic         rd_en,
  output logic [127:0] rd_data,
  output logic         rd_full,
  output logic         rd_empty,
  output logic         rd_overflow,
  output logic [6:0]   rd_count,
  output logic         error
);

  localparam int unsigned CMD_W   = 3 + MIG_BL_WIDTH + ADDR_BITS;
  localparam int unsigned CCNT_W  = $clog2(CMD_DEPTH + 1);
  localparam int unsigned WR_W    = MIG_BYTE_PER_WORD + MIG_DATA_WIDTH;

  // Command FIFO
  logic [CMD_W-1:0]        cmd_dout;
  logic [CCNT_W-1:0]       cmd_cnt;
  logic                    cmd_pop, cmd_drop, cmd_pop_empty;
  logic [2:0]              c_instr;
  logic [MIG_BL_WIDTH-1:0] c_bl;
  logic [ADDR_BITS-1:0]    c_addr;

  sync_fifo_fwft #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_en),
    .din       ({cmd_instr, cmd_bl, cmd_byte_addr[ADDR_BITS+3:4]}),
    .pop       (cmd_pop),
    .dout      (cmd_dout),
    .count     (cmd_cnt),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .push_drop (cmd_drop),
    .pop_empty (cmd_pop_empty)
  );

  assign c_instr = cmd_dout[CMD_W-1 -: 3];
  assign c_bl    = cmd_dout[ADDR_BITS +: MIG_BL_WIDTH];
  assign c_addr  = cmd_dout[ADDR_BITS-1:0];

  // Write-data FIFO
  logic [WR_W-1:0]           wr_dout;
  logic [15:0]               w_mask;
  logic [MIG_DATA_WIDTH-1:0] w_data;
  logic                      wr_pop, wr_drop, wr_pop_empty;

  sync_fifo_fwft #(.WIDTH(WR_W), .DEPTH(DATA_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .din       ({wr_mask, wr_data}),
    .pop       (wr_pop),
    .dout      (wr_dout),
    .count     (wr_count),
    .full      (wr_full),
    .empty     (wr_empty),
    .push_drop (wr_drop),
    .pop_empty (wr_pop_empty)
  );

  assign {w_mask, w_data} = wr_dout;

  // Executor
  exec_state_t          state, state_n;
  logic [ADDR_BITS-1:0] addr;
  logic [6:0]           beats;
  logic                 load, advance, mem_we, rd_push, bad_instr;

  always_comb begin
    state_n     = state;
    cmd_pop     = 1'b0;
    wr_pop      = 1'b0;
    mem_we      = 1'b0;
    rd_push     = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    bad_instr   = 1'b0;
    wr_underrun = 1'b0;
    case (state)
      EX_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          load    = 1'b1;
          case (c_instr)
            MIG_INSTR_WR, MIG_INSTR_WR_AP: state_n = EX_WRITE;
            MIG_INSTR_RD, MIG_INSTR_RD_AP: state_n = EX_READ;
            MIG_INSTR_REF:                 state_n = EX_IDLE;
            default:                       bad_instr = 1'b1;
          endcase
        end
      end
      EX_WRITE: begin
        if (wr_empty) begin
          wr_underrun = 1'b1;
        end else begin
          wr_pop  = 1'b1;
          mem_we  = 1'b1;
          advance = 1'b1;
          if (beats == 7'd1) state_n = EX_IDLE;
        end
      end
      EX_READ: begin
        rd_push = 1'b1;
        advance = 1'b1;
        if (beats == 7'd1) state_n = EX_IDLE;
      end
      default: state_n = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EX_IDLE;
      addr  <= '0;
      beats <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        addr  <= c_addr;
        beats <= {1'b0, c_bl} + 7'd1;
      end else if (advance) begin
        addr  <= addr + ADDR_BITS'(1);
        beats <= beats - 7'd1;
      end
    end
  end

  // Backing memory (contents not reset)
  logic [MIG_DATA_WIDTH-1:0] ram [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int unsigned b = 0; b < MIG_BYTE_PER_WORD; b++) begin
        if (!w_mask[b]) ram[addr][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  // The read FIFO's storage register provides the one-cycle read latency:
  // the word at the issued address is captured on the same edge, so the
  // FIFO shows non-empty the cycle after the address is issued.
  logic rd_drop, rd_pop_empty;

  sync_fifo_fwft #(.WIDTH(MIG_DATA_WIDTH), .DEPTH(DATA_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .din       (ram[addr]),
    .pop       (rd_en),
    .dout      (rd_data),
    .count     (rd_count),
    .full      (rd_full),
    .empty     (rd_empty),
    .push_drop (rd_drop),
    .pop_empty (rd_pop_empty)
  );

  // Sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_overflow <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (rd_drop) rd_overflow <= 1'b1;
      if (cmd_drop || wr_drop || rd_drop || rd_pop_empty || bad_instr) error <= 1'b1;
    end
  end

  // Executor never pops an empty cmd/wr FIFO; these are structurally idle.
  logic unused_bits;
  assign unused_bits = ^{cmd_byte_addr[3:0], cmd_byte_addr[29:ADDR_BITS+4],
                         cmd_cnt, cmd_pop_empty, wr_pop_empty};

endmodule

// File: tb/tb_mig_port_bram.sv
module tb_mig_port_bram;
  import mig_port_bram_pkg::*;

  localparam int unsigned NW = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_en;
  logic [2:0]   cmd_instr;
  logic [5:0]   cmd_bl;
  logic [29:0]  cmd_byte_addr;
  logic         cmd_empty, cmd_full;
  logic         wr_en;
  logic [15:0]  wr_mask;
  logic [127:0] wr_data;
  logic         wr_empty, wr_full, wr_underrun;
  logic [6:0]   wr_count;
  logic         rd_en;
  logic [127:0] rd_data;
  logic         rd_full, rd_empty, rd_overflow;
  logic [6:0]   rd_count;
  logic         error;

  always #5 clk = ~clk;

  mig_port_bram #(.ADDR_BITS(12), .CMD_DEPTH(4), .DATA_DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_empty(wr_empty), .wr_full(wr_full), .wr_count(wr_count), .wr_underrun(wr_underrun),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_overflow(rd_overflow), .rd_count(rd_count), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: plain word array plus queue of words the port must return.
  logic [127:0] mref [NW];
  logic [127:0] expq [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic int unsigned waddr(input logic [29:0] ba);
    return (int'(ba) / 16) % NW;
  endfunction

  function automatic void model_put(input int unsigned a, input logic [15:0] m, input logic [127:0] d);
    for (int b = 0; b < 16; b++)
      if (!m[b]) mref[a][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] ba);
    cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = ba; cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] m, input logic [127:0] d);
    wr_mask = m; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_burst(input logic [29:0] ba, input int unsigned bl,
                             input bit cmd_first, input bit rnd_mask);
    logic [127:0] d [64];
    logic [15:0]  m [64];
    int unsigned  a0;
    a0 = waddr(ba);
    for (int i = 0; i <= int'(bl); i++) begin
      d[i] = {$urandom, $urandom, $urandom, $urandom};
      m[i] = rnd_mask ? 16'($urandom & $urandom) : 16'h0;
      model_put((a0 + i) % NW, m[i], d[i]);
    end
    if (cmd_first) begin
      tick(70);
      send_cmd(MIG_INSTR_WR, 6'(bl), ba);
      tick();
      chk("wr_underrun_stall", wr_underrun, 1);
    end
    for (int i = 0; i <= int'(bl); i++) push_word(m[i], d[i]);
    if (!cmd_first) send_cmd(($urandom_range(0, 1) != 0) ? MIG_INSTR_WR_AP : MIG_INSTR_WR, 6'(bl), ba);
  endtask

  task automatic read_burst(input logic [29:0] ba, input int unsigned bl);
    int unsigned a0;
    a0 = waddr(ba);
    for (int i = 0; i <= int'(bl); i++) expq.push_back(mref[(a0 + i) % NW]);
    send_cmd(($urandom_range(0, 1) != 0) ? MIG_INSTR_RD_AP : MIG_INSTR_RD, 6'(bl), ba);
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while (expq.size() > 0 && budget > 0) begin
      if (!rd_empty && $urandom_range(0, 3) != 0) begin
        chk("rd_data", rd_data, expq.pop_front());
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      tick();
      budget--;
    end
    rd_en = 1'b0;
    chk("drain_words_left", 128'(expq.size()), 128'(0));
    expq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick(2);
    rst = 1'b0;
    expq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] dq [16];
    logic [29:0]  ba;
    int unsigned  bl, w;

    rst = 1'b1; cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0;
    wr_en = 1'b0; wr_mask = '0; wr_data = '0; rd_en = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_cmd_empty", cmd_empty, 1);
    chk("rst_wr_empty", wr_empty, 1);
    chk("rst_rd_empty", rd_empty, 1);
    chk("rst_other_flags", {cmd_full, wr_full, wr_count, wr_underrun, rd_full, rd_overflow, rd_count, error}, 0);

    // Fill words 0..255 with unmasked random data
    for (int k = 0; k < 4; k++) begin
      write_burst(30'(k * 64 * 16), 63, 0, 0);
      tick(80);
    end

    // Write/read round trip with read latency
    for (int i = 0; i < 16; i++) begin
      push_word(16'h0, 128'(i));
      model_put(i, 16'h0, 128'(i));
    end
    send_cmd(MIG_INSTR_WR, 6'd15, 30'h0);
    tick(30);
    for (int i = 0; i < 16; i++) expq.push_back(mref[i]);
    send_cmd(MIG_INSTR_RD, 6'd15, 30'h0);
    chk("lat_cycle1_rd_empty", rd_empty, 1);
    tick();
    chk("lat_cycle2_rd_empty", rd_empty, 1);
    tick();
    chk("lat_cycle3_rd_empty", rd_empty, 0);
    drain();
    chk("roundtrip_error", error, 0);

    // Byte mask: low 8 bytes protected
    push_word(16'h00FF, '1);
    model_put(0, 16'h00FF, '1);
    send_cmd(MIG_INSTR_WR, 6'd0, 30'h0);
    tick(10);
    read_burst(30'h0, 0);
    drain();

    // Randomized traffic in words 0..255, with ignored/out-of-range address bits
    for (int it = 0; it < 150; it++) begin
      bl = $urandom_range(0, 15);
      w  = $urandom_range(0, 255 - bl);
      ba = 30'(w * 16 + $urandom_range(0, 15) + 65536 * $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) write_burst(ba, bl, $urandom_range(0, 1) != 0, 1);
      else begin
        read_burst(ba, bl);
        drain();
      end
    end
    chk("random_error", error, 0);

    // Address wrap
    tick(80);
    write_burst(30'h10000, 3, 0, 0);
    tick(20);
    read_burst(30'h0, 3);
    drain();
    write_burst(30'(4095 * 16), 3, 0, 1);
    tick(20);
    read_burst(30'(4095 * 16), 3);
    drain();
    chk("wrap_error", error, 0);

    // REF is a no-op; undefined instruction is an error
    send_cmd(MIG_INSTR_REF, 6'd0, 30'h0);
    tick(4);
    chk("ref_no_error", error, 0);
    send_cmd(3'b101, 6'd0, 30'h0);
    tick(3);
    chk("bad_instr_error", error, 1);
    do_reset();
    chk("reset_clears_error", error, 0);

    // rd_en while empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    chk("rd_empty_pop_error", error, 1);
    do_reset();

    // Read overflow: second burst entirely dropped
    read_burst(30'h0, 63);
    send_cmd(MIG_INSTR_RD, 6'd63, 30'h0);
    tick(150);
    chk("ovf_rd_count", rd_count, 64);
    chk("ovf_rd_full", rd_full, 1);
    chk("ovf_rd_overflow", rd_overflow, 1);
    chk("ovf_error", error, 1);
    drain();
    chk("ovf_sticky", rd_overflow, 1);
    do_reset();

    // Write stall with command FIFO full: 6 back-to-back WR, 6th dropped
    for (int i = 0; i < 16; i++) begin
      dq[i] = {$urandom, $urandom, $urandom, $urandom};
      model_put(300 + i, 16'h0, dq[i]);
    end
    cmd_instr = MIG_INSTR_WR; cmd_bl = 6'd15; cmd_byte_addr = 30'(300 * 16); cmd_en = 1'b1;
    tick(6);
    cmd_en = 1'b0;
    chk("cf_cmd_full", cmd_full, 1);
    chk("cf_wr_underrun", wr_underrun, 1);
    chk("cf_error", error, 1);
    for (int i = 0; i < 16; i++) push_word(16'h0, dq[i]);
    tick(5);
    chk("cf_next_cmd_stalls", wr_underrun, 1);
    chk("cf_cmd_not_full", cmd_full, 0);
    do_reset();

    // Reset mid-read
    send_cmd(MIG_INSTR_RD, 6'd63, 30'h0);
    tick(5);
    rst = 1'b1;
    tick();
    chk("midrst_rd_empty", rd_empty, 1);
    chk("midrst_cmd_empty", cmd_empty, 1);
    chk("midrst_rd_count", rd_count, 0);
    chk("midrst_error", error, 0);
    rst = 1'b0;
    tick();
    read_burst(30'(300 * 16), 15);
    drain();
    chk("final_error", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
